uart_rx: RTL and testbench

//   Asynchronous serial receiver, partner of the correlator's UART transmitter (same framing, same SHIFT).

---
 rtl/uart_rx.sv | 122 ++++++++++++
 tb/tb_uart_rx.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver with framing check; optional even parity via UART_RX_PARITY_EN.
module uart_rx #(
  parameter int SHIFT      = 4,
  parameter int WORD_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [WORD_WIDTH-1:0] dout,
  output logic                  rx_done,
  output logic                  rx_err,
  output logic                  rx_perr,
  output logic                  rx_busy
);
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int IW = WORD_WIDTH > 1 ? $clog2(WORD_WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORD_WIDTH - 1);
  localparam logic [SHIFT-1:0] MID = SHIFT'(2 ** (SHIFT - 1) - 1);
  localparam logic SLAST = 1'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_e;
  state_e state_q, state_d;
  logic s1_q, rx_s;
  logic [SHIFT-1:0] phase_q, phase_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WORD_WIDTH-1:0] sh_q, sh_d, dout_q, dout_d;
  logic sidx_q, sidx_d, ferr_q, ferr_d, par_q, par_d;
  logic done_q, done_d, err_q, err_d, perr_q, perr_d;
  logic tick;
  assign tick = phase_q == '1;
  assign dout = dout_q;
  assign rx_done = done_q;
  assign rx_err = err_q;
  assign rx_perr = perr_q;
  assign rx_busy = state_q != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      rx_s <= 1'b1;
      state_q <= IDLE;
      phase_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      sidx_q <= 1'b0;
      ferr_q <= 1'b0;
      par_q <= 1'b0;
      dout_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      s1_q <= rx;
      rx_s <= s1_q;
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      sidx_q <= sidx_d;
      ferr_q <= ferr_d;
      par_q <= par_d;
      dout_q <= dout_d;
      done_q <= done_d;
      err_q <= err_d;
      perr_q <= perr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 1'b1;
    idx_d = idx_q;
    sh_d = sh_q;
    sidx_d = sidx_q;
    ferr_d = ferr_q;
    par_d = par_q;
    dout_d = dout_q;
    done_d = 1'b0;
    err_d = err_q;
    perr_d = perr_q;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (!rx_s) state_d = START;
      end
      START: if (phase_q == MID) begin
        phase_d = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        sh_d = (sh_q >> 1) | (WORD_WIDTH'(rx_s) << (WORD_WIDTH - 1));
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_d = '0;
          state_d = PAR ? PARITY : STOP;
        end
      end
      PARITY: if (tick) begin
        par_d = rx_s;
        state_d = STOP;
      end
      STOP: if (tick) begin
        ferr_d = ferr_q | ~rx_s;
        sidx_d = sidx_q + 1'b1;
        if (sidx_q == SLAST) begin
          // Result commits at mid-stop so the next start edge is caught without delay.
          done_d = 1'b1;
          dout_d = sh_q;
          err_d = ferr_d;
          perr_d = PAR && ((^sh_q) != par_q);
          state_d = ferr_d ? WAIT_HIGH : IDLE;
          ferr_d = 1'b0;
          sidx_d = 1'b0;
        end
      end
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx with a scoreboard of expected words checked on rx_done.
module tb_uart_rx;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] dout;
  logic rx_done, rx_err, rx_perr, rx_busy;
  typedef struct packed {logic [7:0] d; logic err; logic perr;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, t_start = 0, done_cyc = 0;
  logic prev_done = 1'b0;

  uart_rx #(.SHIFT(4), .WORD_WIDTH(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .rx(rx), .dout(dout), .rx_done(rx_done),
    .rx_err(rx_err), .rx_perr(rx_perr), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rx_done) begin
      exp_t e;
      done_cyc = cyc;
      chk("done_not_consecutive", {31'd0, prev_done}, 32'd0);
      if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("dout", {24'd0, dout}, {24'd0, e.d});
        chk("rx_err", {31'd0, rx_err}, {31'd0, e.err});
        chk("rx_perr", {31'd0, rx_perr}, {31'd0, e.perr});
      end
    end
    prev_done = rx_done;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic pbit);
    exp_t e;
    e.d = d;
    e.err = ~stop_v;
`ifdef UART_RX_PARITY_EN
    e.perr = (^d) != pbit;
`else
    e.perr = 1'b0;
`endif
    q.push_back(e);
    rx = 1'b0;
    t_start = cyc;
    hold(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold(16);
    end
`ifdef UART_RX_PARITY_EN
    rx = pbit;
    hold(16);
`endif
    rx = stop_v;
    hold(16);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_dout"}, {24'd0, dout}, 32'd0);
    chk({tag, "_done"}, {31'd0, rx_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, rx_err}, 32'd0);
    chk({tag, "_perr"}, {31'd0, rx_perr}, 32'd0);
    chk({tag, "_busy"}, {31'd0, rx_busy}, 32'd0);
  endtask

  initial begin
    #1;
    check_idle_outputs("reset");
    hold(3);
    rst = 1'b0;
    hold(4);
    send_frame(8'h55, 1'b1, 1'b0);
    chk("latency_in_window", {31'd0, (done_cyc - t_start - 1) >= 153 && (done_cyc - t_start - 1) <= 156}, 32'd1);
    hold(10);
    rx = 1'b0;
    hold(4);
    rx = 1'b1;
    chk("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
    hold(8);
    chk("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
    chk("glitch_dout_held", {24'd0, dout}, 32'h55);
    hold(30);
    send_frame(8'hA3, 1'b0, 1'b0);
    hold(40 * 16);
    chk("stuck_low_busy", {31'd0, rx_busy}, 32'd1);
    chk("stuck_low_err_held", {31'd0, rx_err}, 32'd1);
    rx = 1'b1;
    hold(8);
    chk("wait_high_release", {31'd0, rx_busy}, 32'd0);
    hold(16);
    send_frame(8'h12, 1'b1, 1'b0);
    hold(20);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    hold(20);
    chk("b2b_last_dout", {24'd0, dout}, 32'hFF);
    rx = 1'b0;
    hold(16);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      hold(16);
    end
    rx = 1'b1;
    hold(8);
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    hold(5);
    check_idle_outputs("rst_hold");
    rst = 1'b0;
    hold(20);
    send_frame(8'h3C, 1'b1, 1'b0);
    hold(20);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    hold(20);
    chk("par_ok_held", {31'd0, rx_perr}, 32'd0);
    send_frame(8'h07, 1'b1, 1'b0);
    hold(20);
    chk("par_bad_held", {31'd0, rx_perr}, 32'd1);
`else
    send_frame(8'h07, 1'b1, 1'b0);
    hold(20);
    chk("no_par_perr", {31'd0, rx_perr}, 32'd0);
`endif
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
